// File: rtl/rock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rock_pkg
// Description : Shared encodings for the rocking stress regulator: FSM
//               states, heart-rate trend codes, step direction and
//               adjustment target select.
// Revision    : 1.0 - initial release
// ============================================================================
package rock_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    SETTLE = 3'd1,
    EVAL   = 3'd2,
    ADJUST = 3'd3,
    CALM   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FALL  = 2'd0,
    EQUAL = 2'd1,
    RISE  = 2'd2
  } trend_t;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  localparam logic KNOB_FREQ = 1'b0;
  localparam logic KNOB_AMP  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/hart_trend.sv
`default_nettype none
// ============================================================================
// Module      : hart_trend
// Description : Classifies a heart-rate sample against a reference sample as
//               falling, equal (within +/-TOL) or rising. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module hart_trend
  import rock_pkg::*;
#(
  parameter int TOL = 2
) (
  input  logic [7:0] cur,
  input  logic [7:0] prev,
  output trend_t     trend
);

  localparam logic signed [8:0] TOL_S = 9'(TOL);

  logic signed [8:0] diff;

  // Zero-extended 9-bit difference cannot overflow for 8-bit operands.
  always_comb begin
    diff = signed'({1'b0, cur}) - signed'({1'b0, prev});
    if (diff < -TOL_S) begin
      trend = FALL;
    end else if (diff > TOL_S) begin
      trend = RISE;
    end else begin
      trend = EQUAL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stress_regulator.sv
`default_nettype none
// ============================================================================
// Module      : stress_regulator
// Description : Hill-climbing rocking controller. Samples the heart-rate
//               volume on slow ticks, steps freq/amp one unit at a time
//               toward a falling heart rate, and holds settings once calm.
// Revision    : 1.0 - initial release
// ============================================================================
module stress_regulator
  import rock_pkg::*;
#(
  parameter int TOL       = 2,
  parameter int SETTLE_N  = 3,
  parameter int STABLE_N  = 4,
  parameter int FREQ_INIT = 8,
  parameter int AMP_INIT  = 8,
  parameter int LIM_MIN   = 1,
  parameter int LIM_MAX   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] hartvol,
  output logic [3:0] freq,
  output logic [3:0] amp,
  output logic       daal,
  output logic       gelijk,
  output logic       calm
);

  localparam int SCW = $clog2(SETTLE_N + 1);
  localparam int STW = $clog2(STABLE_N + 1);

  state_t           state_q,      state_d;
  logic [3:0]       freq_q,       freq_d;
  logic [3:0]       amp_q,        amp_d;
  logic             daal_q,       daal_d;
  logic             gelijk_q,     gelijk_d;
  logic             calm_q,       calm_d;
  logic             dir_q,        dir_d;
  logic             knob_q,       knob_d;
  logic [7:0]       prev_q,       prev_d;
  logic [7:0]       cur_q,        cur_d;
  logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [STW-1:0]   stable_cnt_q, stable_cnt_d;

  logic [7:0]       trend_cur;
  trend_t           trend;
  logic [STW-1:0]   stable_inc;
  logic [3:0]       knob_val;
  logic [3:0]       knob_next;
  logic             knob_clamp;

  // In CALM the live sample is checked against prev; elsewhere the held one.
  assign trend_cur = (state_q == CALM) ? hartvol : cur_q;

  hart_trend #(
    .TOL (TOL)
  ) u_hart_trend (
    .cur   (trend_cur),
    .prev  (prev_q),
    .trend (trend)
  );

  // Candidate step of the selected setting, holding at the clamp limits.
  always_comb begin
    knob_val   = (knob_q == KNOB_FREQ) ? freq_q : amp_q;
    knob_next  = knob_val;
    knob_clamp = 1'b0;
    if (dir_q == DIR_UP) begin
      if (knob_val >= 4'(LIM_MAX)) knob_clamp = 1'b1;
      else                         knob_next  = knob_val + 4'd1;
    end else begin
      if (knob_val <= 4'(LIM_MIN)) knob_clamp = 1'b1;
      else                         knob_next  = knob_val - 4'd1;
    end
  end

  // Next-state and next-output computation for the regulator FSM.
  always_comb begin
    state_d      = state_q;
    freq_d       = freq_q;
    amp_d        = amp_q;
    daal_d       = daal_q;
    gelijk_d     = gelijk_q;
    calm_d       = calm_q;
    dir_d        = dir_q;
    knob_d       = knob_q;
    prev_d       = prev_q;
    cur_d        = cur_q;
    settle_cnt_d = settle_cnt_q;
    stable_cnt_d = stable_cnt_q;
    stable_inc   = stable_cnt_q + STW'(1);

    case (state_q)
      INIT: begin
        if (tick) begin
          prev_d       = hartvol;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        // Counter parks at SETTLE_N so that after an equal evaluation the
        // very next tick is sampled.
        if (tick) begin
          if (settle_cnt_q == SCW'(SETTLE_N)) begin
            cur_d   = hartvol;
            state_d = EVAL;
          end else begin
            settle_cnt_d = settle_cnt_q + SCW'(1);
          end
        end
      end
      EVAL: begin
        case (trend)
          EQUAL: begin
            gelijk_d     = 1'b1;
            daal_d       = 1'b0;
            stable_cnt_d = stable_inc;
            knob_d       = ~knob_q;
            prev_d       = cur_q;
            if (stable_inc == STW'(STABLE_N)) begin
              calm_d  = 1'b1;
              state_d = CALM;
            end else begin
              state_d = SETTLE;
            end
          end
          FALL: begin
            daal_d       = 1'b1;
            gelijk_d     = 1'b0;
            stable_cnt_d = '0;
            state_d      = ADJUST;
          end
          default: begin
            daal_d       = 1'b0;
            gelijk_d     = 1'b0;
            stable_cnt_d = '0;
            dir_d        = ~dir_q;
            state_d      = ADJUST;
          end
        endcase
      end
      ADJUST: begin
        if (knob_clamp) begin
          dir_d = ~dir_q;
        end else if (knob_q == KNOB_FREQ) begin
          freq_d = knob_next;
        end else begin
          amp_d = knob_next;
        end
        prev_d       = cur_q;
        settle_cnt_d = '0;
        state_d      = SETTLE;
      end
      CALM: begin
        if (tick && (trend != EQUAL)) begin
          calm_d       = 1'b0;
          stable_cnt_d = '0;
          cur_d        = hartvol;
          state_d      = EVAL;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= INIT;
      freq_q       <= 4'(FREQ_INIT);
      amp_q        <= 4'(AMP_INIT);
      daal_q       <= 1'b0;
      gelijk_q     <= 1'b0;
      calm_q       <= 1'b0;
      dir_q        <= DIR_DOWN;
      knob_q       <= KNOB_FREQ;
      prev_q       <= '0;
      cur_q        <= '0;
      settle_cnt_q <= '0;
      stable_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      freq_q       <= freq_d;
      amp_q        <= amp_d;
      daal_q       <= daal_d;
      gelijk_q     <= gelijk_d;
      calm_q       <= calm_d;
      dir_q        <= dir_d;
      knob_q       <= knob_d;
      prev_q       <= prev_d;
      cur_q        <= cur_d;
      settle_cnt_q <= settle_cnt_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  assign freq   = freq_q;
  assign amp    = amp_q;
  assign daal   = daal_q;
  assign gelijk = gelijk_q;
  assign calm   = calm_q;

endmodule
`default_nettype wire

// File: tb/tb_stress_regulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_stress_regulator
// Description : Directed self-checking bench for stress_regulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stress_regulator;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       tick    = 1'b0;
  logic [7:0] hartvol = 8'd0;
  logic [3:0] freq;
  logic [3:0] amp;
  logic       daal;
  logic       gelijk;
  logic       calm;

  int n_checks = 0;
  int n_pass   = 0;

  stress_regulator dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .hartvol (hartvol),
    .freq    (freq),
    .amp     (amp),
    .daal    (daal),
    .gelijk  (gelijk),
    .calm    (calm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One tick strobe, then enough idle cycles for EVAL and ADJUST to finish.
  task automatic pulse(input logic [7:0] v);
    @(negedge clk);
    tick    = 1'b1;
    hartvol = v;
    @(negedge clk);
    tick    = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Three settle ticks followed by the sampled tick.
  task automatic sample(input logic [7:0] v);
    repeat (3) pulse(8'd0);
    pulse(v);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_freq",   freq,   8);
    chk("rst_amp",    amp,    8);
    chk("rst_daal",   daal,   0);
    chk("rst_gelijk", gelijk, 0);
    chk("rst_calm",   calm,   0);
    reset = 1'b1;

    // First falling evaluation with explicit latency checks.
    pulse(8'd100);
    repeat (3) pulse(8'd0);
    @(negedge clk);
    tick    = 1'b1;
    hartvol = 8'd90;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("lat1_freq", freq, 8);
    chk("lat1_daal", daal, 1);
    @(negedge clk);
    chk("lat2_freq", freq, 7);
    chk("lat2_amp",  amp,  8);
    repeat (2) @(negedge clk);

    sample(8'd80);
    chk("fall2_freq", freq, 6);
    chk("fall2_daal", daal, 1);

    sample(8'd85);
    chk("rise_freq",   freq,   7);
    chk("rise_daal",   daal,   0);
    chk("rise_gelijk", gelijk, 0);

    // Four equal evaluations; after the first, each tick is sampled.
    sample(8'd86);
    chk("eq1_gelijk", gelijk, 1);
    chk("eq1_calm",   calm,   0);
    pulse(8'd85);
    chk("eq2_gelijk", gelijk, 1);
    pulse(8'd87);
    chk("eq3_gelijk", gelijk, 1);
    chk("eq3_calm",   calm,   0);
    pulse(8'd85);
    chk("eq4_gelijk", gelijk, 1);
    chk("eq4_calm",   calm,   1);
    chk("eq4_freq",   freq,   7);
    chk("eq4_amp",    amp,    8);

    pulse(8'd86);
    chk("calm_hold", calm, 1);
    chk("calm_hold_freq", freq, 7);
    pulse(8'd95);
    chk("calm_exit",        calm,   0);
    chk("calm_exit_freq",   freq,   6);
    chk("calm_exit_amp",    amp,    8);
    chk("calm_exit_daal",   daal,   0);
    chk("calm_exit_gelijk", gelijk, 0);

    // Drive freq down to the lower clamp.
    sample(8'd90);
    sample(8'd85);
    sample(8'd80);
    sample(8'd75);
    sample(8'd70);
    chk("clamp_reach", freq, 1);
    sample(8'd65);
    chk("clamp_hold",  freq, 1);
    chk("clamp_daal",  daal, 1);
    sample(8'd60);
    chk("clamp_up",    freq, 2);
    sample(8'd55);
    sample(8'd50);
    sample(8'd45);
    chk("pre_rst_freq", freq, 5);

    // Async reset mid-SETTLE.
    pulse(8'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_freq", freq, 8);
    chk("arst_amp",  amp,  8);
    chk("arst_daal", daal, 0);
    chk("arst_calm", calm, 0);
    @(negedge clk);
    reset = 1'b1;

    pulse(8'd200);
    chk("post_init_freq", freq, 8);
    chk("post_init_daal", daal, 0);
    sample(8'd190);
    chk("post_fall_freq", freq, 7);
    chk("post_fall_daal", daal, 1);

    // Extreme sample values.
    sample(8'd255);
    chk("max_rise_freq", freq, 8);
    sample(8'd0);
    chk("zero_fall_freq", freq, 9);
    chk("zero_fall_daal", daal, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
